// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = control unit (drives enables/selects), slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUsrcA;
  logic [1:0] ALUsrcB;
  logic       RegWrite;
  logic       RegDst;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUsrcA, ALUsrcB, RegWrite, RegDst, illegal_op, state
  );

  modport slave (
    output opcode,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUsrcA, ALUsrcB, RegWrite, RegDst, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle datapath: fetch, decode, execute,
// memory and write-back steps, driven only by the instruction opcode.
module multicycle_control (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_r;
  state_t state_next_s;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_supported = 1'b1;
      default:                                      op_supported = 1'b0;
    endcase
  endfunction

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; unused encodings fall back to FETCH
  always_comb begin
    state_next_s = FETCH;
    case (state_r)
      FETCH:   state_next_s = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_RTYPE:     state_next_s = EXECUTE;
          OP_BEQ:       state_next_s = BRANCH;
          OP_J:         state_next_s = JUMP;
          OP_ADDI:      state_next_s = ADDIEX;
          default:      state_next_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.opcode == OP_SW) begin
          state_next_s = MEMWR;
        end else begin
          state_next_s = MEMRD;
        end
      end
      MEMRD:   state_next_s = MEMWB;
      EXECUTE: state_next_s = ALUWB;
      ADDIEX:  state_next_s = ADDIWB;
      default: state_next_s = FETCH;
    endcase
  end

  // Moore outputs per state; illegal_op is the only opcode-dependent output
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.ALUsrcA     = 1'b0;
    bus.ALUsrcB     = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.state       = state_r;
    bus.illegal_op  = (state_r == DECODE) && !op_supported(bus.opcode);
    case (state_r)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
        bus.ALUsrcB = 2'b01;
      end
      DECODE:  bus.ALUsrcB = 2'b11;
      MEMADR: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      EXECUTE: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      BRANCH: begin
        bus.ALUsrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      ADDIEX: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
      end
      ADDIWB:  bus.RegWrite = 1'b1;
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      default: bus.state = state_r;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus reset-abort and
// random-opcode exclusivity sequences.
module tb_multicycle_control;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AD = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,PCSource,ALUOp,ALUsrcA,ALUsrcB,RegWrite,RegDst,illegal_op}
  localparam logic [16:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_ILL    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0,1'b1};
  localparam logic [16:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b0};
  localparam logic [16:0] E_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,2'b00,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b1,1'b0};
  localparam logic [16:0] E_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b1,2'b00,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b0};
  localparam logic [16:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        chk;
    logic [3:0]  es;
    logic [16:0] ec;
  } vec_t;

  vec_t tbl[$];
  int   vectors;
  int   miscompares;
  logic rw_seen;
  logic rw_watch;

  logic [16:0] ctrl_s;
  assign ctrl_s = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                   bus.IRWrite, bus.MemtoReg, bus.PCSource, bus.ALUOp, bus.ALUsrcA,
                   bus.ALUsrcB, bus.RegWrite, bus.RegDst, bus.illegal_op};

  // Flags any RegWrite pulse while a reset-abort window is being watched
  always @(negedge clk) begin
    if (rw_watch && bus.RegWrite) rw_seen = 1'b1;
  end

  task automatic apply(input string tag, input logic rst, input logic [5:0] op,
                       input logic chk, input logic [3:0] es, input logic [16:0] ec);
    reset      = rst;
    bus.opcode = op;
    #1;
    if (chk) begin
      vectors++;
      if (bus.state !== es || ctrl_s !== ec) begin
        miscompares++;
        $display("FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 tag, bus.state, ctrl_s, es, ec);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b1;
    bus.opcode  = 6'd0;
    vectors     = 0;
    miscompares = 0;
    rw_seen     = 1'b0;
    rw_watch    = 1'b0;

    // rst, opcode, check, expected state, expected controls (checked before the edge)
    tbl.push_back('{1'b1, RT,  1'b0, 4'd0,  E_FETCH});
    tbl.push_back('{1'b1, BAD, 1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, BAD, 1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, LW,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b0, LW,  1'b1, 4'd2,  E_MEMADR});
    tbl.push_back('{1'b0, LW,  1'b1, 4'd3,  E_MEMRD});
    tbl.push_back('{1'b0, LW,  1'b1, 4'd4,  E_MEMWB});
    tbl.push_back('{1'b0, SW,  1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, SW,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b0, SW,  1'b1, 4'd2,  E_MEMADR});
    tbl.push_back('{1'b0, SW,  1'b1, 4'd5,  E_MEMWR});
    tbl.push_back('{1'b0, RT,  1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, RT,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b0, RT,  1'b1, 4'd6,  E_EXEC});
    tbl.push_back('{1'b0, RT,  1'b1, 4'd7,  E_ALUWB});
    tbl.push_back('{1'b0, BQ,  1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, BQ,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b0, BQ,  1'b1, 4'd8,  E_BRANCH});
    tbl.push_back('{1'b0, JP,  1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, JP,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b0, JP,  1'b1, 4'd11, E_JUMP});
    tbl.push_back('{1'b0, AD,  1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, AD,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b0, AD,  1'b1, 4'd9,  E_ADDIEX});
    tbl.push_back('{1'b0, AD,  1'b1, 4'd10, E_ADDIWB});
    tbl.push_back('{1'b0, BAD, 1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, BAD, 1'b1, 4'd1,  E_ILL});
    tbl.push_back('{1'b0, BAD, 1'b1, 4'd0,  E_FETCH});
    // lw whose opcode changes after MEMADR: path must stay on the load side
    tbl.push_back('{1'b0, LW,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b0, LW,  1'b1, 4'd2,  E_MEMADR});
    tbl.push_back('{1'b0, SW,  1'b1, 4'd3,  E_MEMRD});
    tbl.push_back('{1'b0, SW,  1'b1, 4'd4,  E_MEMWB});
    // R-type interrupted by reset in EXECUTE
    tbl.push_back('{1'b0, RT,  1'b1, 4'd0,  E_FETCH});
    tbl.push_back('{1'b0, RT,  1'b1, 4'd1,  E_DECODE});
    tbl.push_back('{1'b1, RT,  1'b1, 4'd6,  E_EXEC});
    tbl.push_back('{1'b0, BAD, 1'b1, 4'd0,  E_FETCH});

    foreach (tbl[i]) begin
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].op, tbl[i].chk, tbl[i].es, tbl[i].ec);
    end

    // lw aborted by reset in MEMRD: no register write may follow
    apply("abort_pre", 1'b1, LW, 1'b0, 4'd0, E_FETCH);
    rw_watch = 1'b1;
    apply("abort_fetch",  1'b0, LW, 1'b1, 4'd0, E_FETCH);
    apply("abort_decode", 1'b0, LW, 1'b1, 4'd1, E_DECODE);
    apply("abort_memadr", 1'b0, LW, 1'b1, 4'd2, E_MEMADR);
    apply("abort_memrd",  1'b1, LW, 1'b1, 4'd3, E_MEMRD);
    apply("abort_after",  1'b0, BAD, 1'b1, 4'd0, E_FETCH);
    apply("abort_decode2", 1'b0, BAD, 1'b1, 4'd1, E_ILL);
    rw_watch = 1'b0;
    vectors++;
    if (rw_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_regwrite: RegWrite seen=%b, expected 0", rw_seen);
    end

    // Random opcode stream: write enables must stay mutually exclusive
    for (int c = 0; c < 1000; c++) begin
      logic [5:0] pick;
      case ($urandom_range(0, 7))
        0: pick = RT;
        1: pick = LW;
        2: pick = SW;
        3: pick = BQ;
        4: pick = JP;
        5: pick = AD;
        6: pick = BAD;
        default: pick = 6'($urandom_range(0, 63));
      endcase
      reset      = 1'b0;
      bus.opcode = pick;
      #1;
      vectors++;
      if ((bus.MemRead && bus.MemWrite) || (bus.PCWrite && bus.PCWriteCond) || bus.state > 4'd11) begin
        miscompares++;
        $display("FAIL random_excl cycle %0d: state=%0d MemRead=%b MemWrite=%b PCWrite=%b PCWriteCond=%b, expected exclusive",
                 c, bus.state, bus.MemRead, bus.MemWrite, bus.PCWrite, bus.PCWriteCond);
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle processor datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back steps. Every cycle it drives the datapath select and enable signals, including the ALUsrcA select consumed by the ALU source-A mux (0 = PC, 1 = A register). It sits beside the datapath and takes only the opcode field of the instruction register as input.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register; stable from DECODE until the next FETCH.
- PCWrite  output  1  unconditional PC write enable.
- PCWriteCond  output  1  PC write enable qualified by ALU zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write-data select: 0 = ALUOut, 1 = MDR.
- PCSource  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
- ALUsrcA  output  1  ALU operand A select: 0 = PC, 1 = A.
- ALUsrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  destination register: 0 = rt, 1 = rd.
- illegal_op  output  1  high in DECODE when the opcode is unsupported.
- state  output  4  current state encoding, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State encoding and Moore outputs:
  - FETCH = 0: MemRead, IRWrite, PCWrite = 1; IorD = 0, ALUsrcA = 0, ALUsrcB = 01, ALUOp = 00, PCSource = 00.
  - DECODE = 1: ALUsrcA = 0, ALUsrcB = 11, ALUOp = 00.
  - MEMADR = 2: ALUsrcA = 1, ALUsrcB = 10, ALUOp = 00.
  - MEMRD = 3: MemRead = 1, IorD = 1.
  - MEMWB = 4: RegWrite = 1, MemtoReg = 1, RegDst = 0.
  - MEMWR = 5: MemWrite = 1, IorD = 1.
  - EXECUTE = 6: ALUsrcA = 1, ALUsrcB = 00, ALUOp = 10.
  - ALUWB = 7: RegWrite = 1, RegDst = 1, MemtoReg = 0.
  - BRANCH = 8: ALUsrcA = 1, ALUsrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
  - ADDIEX = 9: ALUsrcA = 1, ALUsrcB = 10, ALUOp = 00.
  - ADDIWB = 10: RegWrite = 1, RegDst = 0, MemtoReg = 0.
  - JUMP = 11: PCWrite = 1, PCSource = 10.
- Any output not listed for a state is 0.
- Transitions:
  - FETCH → DECODE always.
  - DECODE → MEMADR (lw/sw), EXECUTE (R-type), BRANCH (beq), JUMP (j), ADDIEX (addi); any other opcode → FETCH.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB → FETCH.
- Unused encodings 12–15 → FETCH on the next clock; all outputs are 0 while in them.
- illegal_op = 1 only when state == DECODE and the opcode is unsupported. It is combinational and not latched.

## Timing
- State register updates on the rising edge of clk. All outputs are a combinational function of state, and illegal_op also of opcode. No output depends combinationally on any other input.
- reset high at an edge forces state = FETCH, whatever the current state. Mid-instruction reset abandons the instruction with no further writes issued.
- Outputs after reset are therefore the FETCH values: MemRead = IRWrite = PCWrite = 1, all other outputs 0, state = 0.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Opcode is sampled at the DECODE → next edge and at the MEMADR → next edge. Changes to opcode in other states have no effect.
- PCWrite and PCWriteCond are never both 1 in the same cycle.
- MemRead and MemWrite are never both 1 in the same cycle.

## Test plan
- Reset: hold reset 2 cycles from an arbitrary state → state = 0, MemRead = IRWrite = PCWrite = 1, ALUsrcA = 0, ALUsrcB = 01, all others 0.
- lw (100011): state sequence 0,1,2,3,4,0. ALUsrcA = 1 in state 2. MemRead = IorD = 1 in state 3. RegWrite = MemtoReg = 1 in state 4.
- sw (101011) and R-type (000000):
  - sw sequence 0,1,2,5,0, with MemWrite = 1 only in state 5.
  - R-type sequence 0,1,6,7,0, with ALUOp = 10 in state 6 and RegDst = RegWrite = 1 in state 7.
- beq (000100) and j (000010):
  - beq sequence 0,1,8,0, with PCWriteCond = 1 and PCSource = 01 in state 8.
  - j sequence 0,1,11,0, with PCWrite = 1 and PCSource = 10 in state 11.
- addi (001000), then opcode 111111:
  - addi sequence 0,1,9,10,0.
  - Opcode 111111 sequence 0,1,0, with illegal_op = 1 for exactly one cycle in state 1.
- Reset asserted in MEMRD of a lw → next state 0, and RegWrite never asserts for that instruction. Random opcode stream for 1000 cycles → MemRead/MemWrite and PCWrite/PCWriteCond never both high.
